mult_sched: RTL and testbench
=============================

MULT_SCHED -- requirements
Module: mult_sched

Interface
REQ-001 Parameter W, default 8: operand width in bits; unsigned.
REQ-002 Parameter N, default 4: number of requesters; range 2..8.
REQ-003 Parameter DIV, default 512: sample period in clk cycles; power of two, at least 2*N*(W+2).
REQ-004 Port clk, input, 1: single system clock; all state changes on its rising edge.
REQ-005 Port arstn, input, 1: reset; asynchronous, active-low.
REQ-006 Port req, input, N: per-requester multiply request, level.
REQ-007 Port op_a, input, N*W: operand A of requester i at bits [i*W +: W].
REQ-008 Port op_b, input, N*W: operand B of requester i at bits [i*W +: W].
REQ-009 Port ovr_clr, input, 1: clears overrun when high for one cycle.
REQ-010 Port gnt, output, N: one-hot, one-cycle pulse; operands of the granted requester are captured in that cycle.
REQ-011 Port busy, output, 1: high whenever the FSM is not in IDLE.
REQ-012 Port res, output, 2W: last product; holds its value until the next completion.
REQ-013 Port res_valid, output, 1: one-cycle pulse when res is updated.
REQ-014 Port res_id, output, clog2(N): index of the requester owning res.
REQ-015 Port sample_tick, output, 1: one-cycle pulse every DIV cycles.
REQ-016 Port overrun, output, 1: sticky service-overrun flag.

Function
REQ-017 The block shall share one sequential shift-add multiplier among N requesters; it shall contain no combinational W x W multiplier.
REQ-018 FSM states: IDLE, MUL, DONE. IDLE -> MUL when any req bit is high; MUL -> DONE after exactly W MUL cycles; DONE -> IDLE unconditionally.
REQ-019 In the cycle IDLE -> MUL, the block shall select the winner by round-robin, starting at index (last_granted+1) mod N.
REQ-020 In that same cycle, the block shall pulse gnt[winner], latch op_a/op_b of the winner, clear the accumulator, and update last_granted to the winner.
REQ-021 Each MUL cycle: if the current LSB of B is 1, the shifted A shall be added into the 2W-bit accumulator; A shall then shift left 1 and B shall shift right 1.
REQ-022 Latency: gnt pulse in cycle t; res, res_id and res_valid shall be updated in cycle t+W+1; the next gnt shall occur no earlier than t+W+2.
REQ-023 Arithmetic: res = op_a*op_b, unsigned, full 2W bits, no truncation.
REQ-024 The handshake shall be as follows: a requester holds req until it sees its gnt; req still high in the cycle after gnt shall be treated as a new request.
REQ-025 Operand inputs may change after gnt without affecting the product in flight.
REQ-026 Requests arriving during MUL/DONE shall not be granted until IDLE; no gnt shall occur while busy.
REQ-027 The sample counter shall be free-running, mod DIV; sample_tick shall be high when the count equals DIV-1.
REQ-028 overrun shall set on any sample_tick cycle in which busy is high or any req bit is high without a gnt in that cycle.
REQ-029 ovr_clr shall clear overrun; on simultaneous set and clear, set shall win.
REQ-030 The sample counter shall be independent of the FSM; arbitration shall not stall or shift the tick.

Reset
REQ-031 While arstn is low: state IDLE; gnt, busy, res, res_valid, res_id, sample_tick and overrun shall all be 0; sample counter 0; last_granted = N-1, so that req[0] wins first.
REQ-032 Reset asserted mid-MUL shall abort the operation; no res_valid shall be issued for it after release.
REQ-033 Reset release shall be synchronised internally, so that the first state change occurs on a clk edge after arstn rises.

Verification
REQ-034 Single request (W=8): req[2]=1, op_a[2]=200, op_b[2]=3 -> gnt=4'b0100 in cycle t; res=600, res_id=2 and res_valid=1 in cycle t+9.
REQ-035 Round-robin: all four req high from reset release, each dropped on its gnt -> grant order 0,1,2,3, gnt pulses 10 cycles apart, no gnt while busy.
REQ-036 Boundary products: 255*255 -> res=65025; 0*173 -> res=0; 1*255 -> res=255; op_b changed after gnt -> product unaffected.
REQ-037 Tick timing: first sample_tick 511 cycles after reset release, then one every 512 cycles, unaffected by continuous requests.
REQ-038 Overrun: req[1] held high across a sample_tick while busy -> overrun=1 and stays 1; ovr_clr pulsed in the same cycle as a new overrun condition -> overrun stays 1; ovr_clr pulsed alone -> overrun returns to 0.
REQ-039 Reset mid-operation: arstn pulled low 3 cycles after gnt -> all outputs 0 immediately; after release, no res_valid appears and req[0] is granted first.

Source files
------------

// File: rtl/mult_sched.sv
// Round-robin scheduler that shares one shift-add multiplier among N requesters,
// with a free-running sample tick and a sticky service-overrun flag.
module mult_sched #(
    parameter int W   = 8,
    parameter int N   = 4,
    parameter int DIV = 512,
    localparam int IW = $clog2(N),
    localparam int CW = $clog2(DIV),
    localparam int KW = $clog2(W + 1)
) (
    input  logic             clk,
    input  logic             arstn,
    input  logic [N-1:0]     req,
    input  logic [N*W-1:0]   op_a,
    input  logic [N*W-1:0]   op_b,
    input  logic             ovr_clr,
    output logic [N-1:0]     gnt,
    output logic             busy,
    output logic [2*W-1:0]   res,
    output logic             res_valid,
    output logic [IW-1:0]    res_id,
    output logic             sample_tick,
    output logic             overrun
);

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    state_t         state;
    logic           sync1;
    logic           run;
    logic [CW-1:0]  cnt;
    logic [IW-1:0]  last;
    logic [IW-1:0]  win;
    logic [IW-1:0]  idx;
    logic           any;
    logic [2*W-1:0] a_sh;
    logic [2*W-1:0] acc;
    logic [2*W-1:0] acc_nxt;
    logic [W-1:0]   b_sh;
    logic [KW-1:0]  step;
    logic           ovr_set;

    // run follows the release of arstn by two edges so the FSM never starts on a partial edge
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            sync1 <= 1'b0;
            run   <= 1'b0;
        end else begin
            sync1 <= 1'b1;
            run   <= sync1;
        end
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) cnt <= '0;
        else        cnt <= cnt + CW'(1);
    end

    assign sample_tick = (cnt == CW'(DIV - 1));

    // Scan from last+N down to last+1 so the nearest requester after last wins.
    always_comb begin
        win = '0;
        any = 1'b0;
        idx = '0;
        for (int k = N; k >= 1; k--) begin
            idx = IW'((int'(last) + k) % N);
            if (req[idx]) begin
                win = idx;
                any = 1'b1;
            end
        end
    end

    assign busy    = (state != IDLE);
    assign gnt     = (run && state == IDLE && any) ? ({{(N-1){1'b0}}, 1'b1} << win) : '0;
    assign acc_nxt = b_sh[0] ? (acc + a_sh) : acc;

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state     <= IDLE;
            last      <= IW'(N - 1);
            a_sh      <= '0;
            b_sh      <= '0;
            acc       <= '0;
            step      <= '0;
            res       <= '0;
            res_id    <= '0;
            res_valid <= 1'b0;
        end else begin
            res_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (run && any) begin
                        state <= MUL;
                        last  <= win;
                        a_sh  <= {{W{1'b0}}, op_a[win*W +: W]};
                        b_sh  <= op_b[win*W +: W];
                        acc   <= '0;
                        step  <= KW'(W - 1);
                    end
                end
                MUL: begin
                    acc  <= acc_nxt;
                    a_sh <= a_sh << 1;
                    b_sh <= b_sh >> 1;
                    step <= step - KW'(1);
                    if (step == '0) begin
                        state     <= DONE;
                        res       <= acc_nxt;
                        res_id    <= last;
                        res_valid <= 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign ovr_set = sample_tick && (busy || ((|req) && !(|gnt)));

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) overrun <= 1'b0;
        else        overrun <= ovr_set || (overrun && !ovr_clr);
    end

endmodule

// File: tb/tb_mult_sched.sv
// Scoreboard bench for mult_sched: a reference model predicts grants, products,
// ticks and overrun from the rules; a separate monitor checks every result.
module tb_mult_sched;
    localparam int W = 8;
    localparam int N = 4;
    localparam int DIV = 512;

    logic           clk = 1'b0;
    logic           arstn = 1'b0;
    logic           ovr_clr = 1'b0;
    logic [N-1:0]   req = '0;
    logic [N*W-1:0] op_a = '0;
    logic [N*W-1:0] op_b = '0;
    logic [N-1:0]   gnt;
    logic           busy;
    logic [2*W-1:0] res;
    logic           res_valid;
    logic [1:0]     res_id;
    logic           sample_tick;
    logic           overrun;

    mult_sched #(.W(W), .N(N), .DIV(DIV)) dut (
        .clk(clk), .arstn(arstn), .req(req), .op_a(op_a), .op_b(op_b),
        .ovr_clr(ovr_clr), .gnt(gnt), .busy(busy), .res(res),
        .res_valid(res_valid), .res_id(res_id), .sample_tick(sample_tick),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint p;
        int     id;
        int     g;
    } exp_t;

    exp_t         sb[$];
    int           glog[$];
    int           glog_c[$];
    logic [N-1:0] granted = '0;
    int           cyc = 0;
    int           c0 = 0;
    int           n_checks = 0;
    int           n_errors = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Reference model: round-robin grants, busy window, tick period, overrun flag.
    initial begin
        int m_last, m_lastg, rel, w;
        bit m_ovr, m_busy, exp_g, exp_tick, set, found;
        logic [N-1:0] exp_vec;
        exp_t e;
        m_last = N - 1; m_lastg = -1000; m_ovr = 0;
        forever begin
            @(negedge clk); #1;
            if (gnt != 0)
                for (int k = 0; k < N; k++)
                    if (gnt[k]) begin glog.push_back(k); glog_c.push_back(cyc); end
            if (!arstn) begin
                m_last = N - 1; m_lastg = -1000; m_ovr = 0;
                sb.delete();
                chk("rst_gnt", gnt, 0);
                chk("rst_busy", busy, 0);
                chk("rst_tick", sample_tick, 0);
                chk("rst_ovr", overrun, 0);
            end else begin
                rel = cyc - c0;
                m_busy = (cyc - m_lastg >= 1) && (cyc - m_lastg <= W + 1);
                exp_tick = ((rel % DIV) == DIV - 1);
                if (sample_tick || exp_tick) chk("tick", sample_tick, exp_tick);
                chk("busy", busy, m_busy);
                exp_g = !m_busy && rel >= 2 && (req != 0);
                exp_vec = '0; w = 0; found = 0;
                if (exp_g) begin
                    for (int k = 1; k <= N; k++)
                        if (!found && req[(m_last + k) % N]) begin
                            w = (m_last + k) % N; found = 1;
                        end
                    exp_vec[w] = 1'b1;
                end
                if (gnt != 0 || exp_g) chk("gnt", gnt, exp_vec);
                if (exp_g) begin
                    e.p  = longint'(op_a[w*W +: W]) * longint'(op_b[w*W +: W]);
                    e.id = w;
                    e.g  = cyc;
                    sb.push_back(e);
                    m_last = w; m_lastg = cyc; granted[w] = 1'b1;
                end
                chk("overrun", overrun, m_ovr);
                set = exp_tick && (m_busy || (req != 0 && !exp_g));
                if (set) m_ovr = 1;
                else if (ovr_clr) m_ovr = 0;
            end
        end
    end

    // Result monitor: pops the scoreboard whenever the DUT presents a product.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk); #1;
            if (arstn) begin
                if (res_valid) begin
                    if (sb.size() == 0) chk("spurious_valid", res_valid, 0);
                    else begin
                        e = sb.pop_front();
                        chk("res", res, e.p);
                        chk("res_id", res_id, e.id);
                        chk("latency", cyc - e.g, W + 1);
                    end
                end else if (sb.size() > 0 && cyc - sb[0].g > W + 1) begin
                    chk("missing_valid", res_valid, 1);
                    void'(sb.pop_front());
                end
            end
        end
    end

    // Requester agents: drop req after a grant and scramble operands mid-flight.
    initial forever begin
        @(negedge clk);
        for (int i = 0; i < N; i++)
            if (granted[i]) begin
                granted[i] = 1'b0;
                req[i] = 1'b0;
                op_a[i*W +: W] = W'($urandom);
                op_b[i*W +: W] = W'($urandom);
            end
    end

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return W'(1);
            default: return W'($urandom);
        endcase
    endfunction

    task automatic request(input int i, input int a, input int b);
        int t = 0;
        @(negedge clk);
        while ((req[i] || granted[i]) && t < 100) begin @(negedge clk); t++; end
        op_a[i*W +: W] = W'(a);
        op_b[i*W +: W] = W'(b);
        req[i] = 1'b1;
    endtask

    task automatic run_one(input int i, input int a, input int b, input longint exp);
        logic [N-1:0] g = '0;
        int t = 0;
        request(i, a, b);
        #1;
        while (!res_valid && t < 60) begin
            if (gnt != 0) g = gnt;
            @(negedge clk); #1; t++;
        end
        chk("dir_done", res_valid, 1);
        chk("dir_gnt", g, longint'(1) << i);
        chk("dir_res", res, exp);
        chk("dir_id", res_id, i);
    endtask

    task automatic wait_phase(input int p);
        int t = 0;
        do begin @(negedge clk); t++; end
        while (((cyc - c0) % DIV) != p && t < 2 * DIV);
    endtask

    task automatic drain();
        int t = 0;
        while ((req != 0 || busy || sb.size() != 0) && t < 300) begin
            @(negedge clk); #1; t++;
        end
        chk("drain", (req != 0 || busy || sb.size() != 0), 0);
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_gnt"}, gnt, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_res"}, res, 0);
        chk({tag, "_valid"}, res_valid, 0);
        chk({tag, "_id"}, res_id, 0);
        chk({tag, "_tick"}, sample_tick, 0);
        chk({tag, "_ovr"}, overrun, 0);
    endtask

    initial begin
        req = '1;
        for (int i = 0; i < N; i++) begin
            op_a[i*W +: W] = W'(10 + i);
            op_b[i*W +: W] = W'(20 + i);
        end
        repeat (3) @(negedge clk);
        #1 check_outputs_zero("reset");

        // Round-robin from release with all four requesting.
        @(negedge clk);
        c0 = cyc; arstn = 1'b1;
        glog.delete(); glog_c.delete();
        repeat (50) @(negedge clk);
        chk("rr_count", glog.size(), 4);
        for (int k = 0; k < 4; k++)
            if (k < glog.size()) chk("rr_order", glog[k], k);
        for (int k = 0; k < 3; k++)
            if (k + 1 < glog.size()) chk("rr_gap", glog_c[k+1] - glog_c[k], W + 2);
        drain();

        run_one(2, 200, 3, 600);
        run_one(0, 255, 255, 65025);
        run_one(0, 0, 173, 0);
        run_one(0, 1, 255, 255);
        run_one(3, 255, 1, 255);
        drain();

        // Random contention across several tick periods.
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++)
                if (!req[i] && !granted[i] && $urandom_range(0, 2) == 0) begin
                    op_a[i*W +: W] = pick();
                    op_b[i*W +: W] = pick();
                    req[i] = 1'b1;
                end
        end
        drain();

        // Overrun: clear alone, set while busy, then clear racing a set.
        wait_phase(100);
        ovr_clr = 1'b1;
        @(negedge clk); ovr_clr = 1'b0;
        @(negedge clk); #1 chk("ovr_clear_alone", overrun, 0);
        wait_phase(505);
        op_a[0 +: W] = 8'd9;  op_b[0 +: W] = 8'd7;
        op_a[W +: W] = 8'd11; op_b[W +: W] = 8'd13;
        req[0] = 1'b1; req[1] = 1'b1;
        wait_phase(520); #1 chk("ovr_set_busy", overrun, 1);
        wait_phase(505);
        req[2] = 1'b1; req[3] = 1'b1;
        wait_phase(511);
        ovr_clr = 1'b1;
        @(negedge clk); ovr_clr = 1'b0;
        wait_phase(520); #1 chk("ovr_set_wins", overrun, 1);
        wait_phase(100);
        ovr_clr = 1'b1;
        @(negedge clk); ovr_clr = 1'b0;
        @(negedge clk); #1 chk("ovr_clear_after", overrun, 0);
        drain();

        // Reset three cycles into a multiply.
        request(1, 77, 99);
        repeat (3) @(negedge clk);
        arstn = 1'b0;
        req = '1;
        #1 check_outputs_zero("midrst");
        repeat (4) @(negedge clk);
        c0 = cyc; arstn = 1'b1;
        glog.delete(); glog_c.delete();
        repeat (60) @(negedge clk);
        #1 chk("post_rst_first", (glog.size() > 0) ? glog[0] : -1, 0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
